// File: rtl/axistream_pack_keep_if.sv
// Bus bundle for the packer: a narrow source stream in and a wide, keep-qualified
// destination stream out. The design sits on the slave modport; a driver/consumer
// pair sits on the master modport.
interface axistream_pack_keep_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4
);
  logic                           src_tvalid;
  logic                           src_tready;
  logic [DATA_WIDTH-1:0]          src_tdata;
  logic                           src_tlast;
  logic                           dest_tvalid;
  logic                           dest_tready;
  logic [DATA_WIDTH*NUM_PACK-1:0] dest_tdata;
  logic [NUM_PACK-1:0]            dest_tkeep;
  logic                           dest_tlast;

  modport slave (
    input  src_tvalid, src_tdata, src_tlast, dest_tready,
    output src_tready, dest_tvalid, dest_tdata, dest_tkeep, dest_tlast
  );

  modport master (
    output src_tvalid, src_tdata, src_tlast, dest_tready,
    input  src_tready, dest_tvalid, dest_tdata, dest_tkeep, dest_tlast
  );
endinterface

// File: rtl/axistream_pack_keep.sv
// Gathers up to NUM_PACK narrow source beats into one wide destination word.
// A tlast on any beat closes the word early; unfilled lanes are zero and their
// keep bits are clear. An assembly stage feeds a single output register, so one
// source beat per cycle is accepted whenever the consumer is ready.
module axistream_pack_keep #(
  parameter int   DATA_WIDTH = 8,
  parameter int   NUM_PACK   = 4,
  parameter logic BIG_ENDIAN = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  axistream_pack_keep_if.slave        bus,
  output logic                        short_word
);
  localparam int IDX_W  = $clog2(NUM_PACK);
  localparam int WORD_W = DATA_WIDTH * NUM_PACK;

  logic [IDX_W-1:0]    idx_p0;
  logic [WORD_W-1:0]   asm_data_p0;
  logic [NUM_PACK-1:0] asm_keep_p0;
  logic [WORD_W-1:0]   out_data_p1;
  logic [NUM_PACK-1:0] out_keep_p1;
  logic                out_last_p1;
  logic                vld_p1;

  logic [IDX_W-1:0]    lane;
  logic [WORD_W-1:0]   merged_data;
  logic [NUM_PACK-1:0] merged_keep;
  logic                src_ready;
  logic                accept;
  logic                close;
  logic                pop;

  // Handshake: the source may only advance when the output register can take a word.
  assign src_ready = rst && (!vld_p1 || bus.dest_tready);
  assign accept    = bus.src_tvalid && src_ready;
  assign pop       = vld_p1 && bus.dest_tready;
  assign close     = (idx_p0 == IDX_W'(NUM_PACK - 1)) || bus.src_tlast;
  assign lane      = BIG_ENDIAN ? (IDX_W'(NUM_PACK - 1) - idx_p0) : idx_p0;

  // Merge the incoming element into the partial word at its lane.
  always_comb begin
    merged_data = asm_data_p0;
    merged_keep = asm_keep_p0;
    for (int k = 0; k < NUM_PACK; k++) begin
      if (lane == IDX_W'(k)) begin
        merged_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.src_tdata;
        merged_keep[k]                          = 1'b1;
      end
    end
  end

  // ---- stage p0: assembly of the partial word ----
  // Accumulate beats; a closing beat hands the word on and restarts at lane index 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_p0      <= '0;
      asm_data_p0 <= '0;
      asm_keep_p0 <= '0;
    end else if (accept) begin
      if (close) begin
        idx_p0      <= '0;
        asm_data_p0 <= '0;
        asm_keep_p0 <= '0;
      end else begin
        idx_p0      <= idx_p0 + IDX_W'(1);
        asm_data_p0 <= merged_data;
        asm_keep_p0 <= merged_keep;
      end
    end
  end

  // ---- stage p1: output register ----
  // Load a closed word (replacing one being popped the same cycle) or drop valid on pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
      out_keep_p1 <= '0;
      out_last_p1 <= 1'b0;
    end else if (accept && close) begin
      vld_p1      <= 1'b1;
      out_data_p1 <= merged_data;
      out_keep_p1 <= merged_keep;
      out_last_p1 <= bus.src_tlast;
    end else if (pop) begin
      vld_p1 <= 1'b0;
    end
  end

  // Flag, one cycle later, every accepted word that is not completely filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      short_word <= 1'b0;
    end else begin
      short_word <= pop && (out_keep_p1 != {NUM_PACK{1'b1}});
    end
  end

  assign bus.src_tready  = src_ready;
  assign bus.dest_tvalid = vld_p1;
  assign bus.dest_tdata  = out_data_p1;
  assign bus.dest_tkeep  = out_keep_p1;
  assign bus.dest_tlast  = out_last_p1;
endmodule
